// File: rtl/neuron_seq_pkg.sv
// -----------------------------------------------------------------------------
// neuron_seq_pkg
// Shared definitions for the neuron MAC sequencer:
//   state_t             - sequencer state encoding (3 bits, IDLE=0 .. DONE=4)
//   SEL_W               - width of the shared coefficient/sample select
//   default_acc_width() - accumulator width that holds 2*NumTaps products
//                         plus the offset without overflow
// -----------------------------------------------------------------------------
package neuron_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_OFFSET = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int SEL_W = 4;

    function automatic int default_acc_width(input int width);
        return 2 * width + 5;
    endfunction

endpackage

// File: rtl/neuron_sat_relu.sv
// -----------------------------------------------------------------------------
// neuron_sat_relu
// Combinational narrowing of the signed accumulator sum to the neuron output
// width. Values outside [-2^(OutWidth-1), 2^(OutWidth-1)-1] are clamped.
// Optional feature macro NEURON_SEQ_RELU_EN: when defined, a negative
// saturated value is replaced by 0 (ReLU activation).
// Ports:
//   din  in  InWidth   signed accumulator sum
//   dout out OutWidth  signed saturated (and optionally rectified) value
// -----------------------------------------------------------------------------
module neuron_sat_relu #(
    parameter int InWidth  = 13,
    parameter int OutWidth = 4
) (
    input  logic signed [InWidth-1:0]  din,
    output logic signed [OutWidth-1:0] dout
);

    localparam logic signed [InWidth-1:0] MAX_V = InWidth'(2 ** (OutWidth - 1) - 1);
    // Bitwise inverse of 2^k-1 is -2^k in two's complement.
    localparam logic signed [InWidth-1:0] MIN_V = ~MAX_V;

    logic signed [OutWidth-1:0] sat;

    always_comb begin
        sat = din[OutWidth-1:0];
        if (din > MAX_V) begin
            sat = MAX_V[OutWidth-1:0];
        end else if (din < MIN_V) begin
            sat = MIN_V[OutWidth-1:0];
        end
    end

`ifdef NEURON_SEQ_RELU_EN
    assign dout = sat[OutWidth-1] ? '0 : sat;
`else
    assign dout = sat;
`endif

endmodule

// File: rtl/neuron_mac_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_mac_sequencer
// Control and accumulate engine for one neuron. A Start in IDLE loads the
// coefficient bank (one EnableRegisterIn cycle), steps the shared select
// through NumTaps taps accumulating CoeffX*DataX + CoeffY*DataY, adds Offset,
// saturates into Result and pulses Done.
// Optional feature macro NEURON_SEQ_RELU_EN (see neuron_sat_relu).
// Ports:
//   CLK, reset_n        clock (rising edge), async active-low reset
//   Start               evaluation request, sampled only in IDLE
//   Busy                high in every state except IDLE
//   Done                one-cycle pulse in DONE; Result valid from same edge
//   EnableRegisterIn    coefficient bank load strobe (LOAD state)
//   SELCoeffX/Y         shared tap select (idx in ACCUM, 0 otherwise)
//   CoeffX/Y, DataX/Y   signed selected coefficients / samples
//   Offset              signed bank offset
//   Result              signed saturated output, registered, held
//   DbgState            current sequencer state
// Handshake: Start is a level request; it is taken on any edge where the
// sequencer is in IDLE and ignored (not queued) otherwise. Done is a single
// cycle qualifier for Result with no back-pressure.
// -----------------------------------------------------------------------------
module neuron_mac_sequencer
    import neuron_seq_pkg::*;
#(
    parameter int Width    = 4,
    parameter int NumTaps  = 10,
    parameter int AccWidth = default_acc_width(Width)
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    output logic                    EnableRegisterIn,
    output logic [SEL_W-1:0]        SELCoeffX,
    output logic [SEL_W-1:0]        SELCoeffY,
    input  logic signed [Width-1:0] CoeffX,
    input  logic signed [Width-1:0] CoeffY,
    input  logic signed [Width-1:0] DataX,
    input  logic signed [Width-1:0] DataY,
    input  logic signed [Width-1:0] Offset,
    output logic signed [Width-1:0] Result,
    output logic [2:0]              DbgState
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NumTaps - 1);

    state_t                      state_q, state_d;
    logic [SEL_W-1:0]            idx_q, idx_d;
    logic signed [AccWidth-1:0]  acc_q, acc_d;
    logic signed [Width-1:0]     result_q, result_d;

    logic signed [2*Width-1:0]   prod_x, prod_y;
    logic signed [AccWidth-1:0]  sum_off;
    logic signed [Width-1:0]     sat_out;

    assign prod_x  = CoeffX * DataX;
    assign prod_y  = CoeffY * DataY;
    assign sum_off = acc_q + AccWidth'(Offset);

    neuron_sat_relu #(
        .InWidth (AccWidth),
        .OutWidth(Width)
    ) u_sat (
        .din (sum_off),
        .dout(sat_out)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        acc_d            = acc_q;
        result_d         = result_q;
        Busy             = (state_q != ST_IDLE);
        Done             = (state_q == ST_DONE);
        EnableRegisterIn = (state_q == ST_LOAD);
        SELCoeffX        = (state_q == ST_ACCUM) ? idx_q : '0;

        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                acc_d   = '0;
                idx_d   = '0;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                // Products are sign-extended before the add so the
                // accumulator never wraps.
                acc_d = acc_q + AccWidth'(prod_x) + AccWidth'(prod_y);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_OFFSET;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            ST_OFFSET: begin
                result_d = sat_out;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign SELCoeffY = SELCoeffX;
    assign Result    = result_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
module tb_neuron_mac_sequencer;

    localparam int W = 4;
    localparam int N = 10;
    localparam int MAXV = 2 ** (W - 1) - 1;
    localparam int MINV = -(2 ** (W - 1));

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    logic Start = 1'b0;
    always #5 CLK = ~CLK;

    logic                Busy, Done, EnableRegisterIn;
    logic [3:0]          SELCoeffX, SELCoeffY;
    logic signed [W-1:0] CoeffX, CoeffY, DataX, DataY, Offset, Result;
    logic [2:0]          DbgState;

    // Coefficient bank and sample muxes modelled as arrays on the select.
    logic signed [W-1:0] cx[16], cy[16], dx[16], dy[16];
    logic signed [W-1:0] off;

    assign CoeffX = cx[SELCoeffX];
    assign CoeffY = cy[SELCoeffY];
    assign DataX  = dx[SELCoeffX];
    assign DataY  = dy[SELCoeffY];
    assign Offset = off;

    neuron_mac_sequencer #(.Width(W), .NumTaps(N)) dut (
        .CLK(CLK), .reset_n(reset_n), .Start(Start),
        .Busy(Busy), .Done(Done), .EnableRegisterIn(EnableRegisterIn),
        .SELCoeffX(SELCoeffX), .SELCoeffY(SELCoeffY),
        .CoeffX(CoeffX), .CoeffY(CoeffY), .DataX(DataX), .DataY(DataY),
        .Offset(Offset), .Result(Result), .DbgState(DbgState)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_cnt = cycles since the edge that accepted Start, -1 when idle.
    int m_cnt = -1;
    int m_result = 0;
    logic signed [W-1:0] exp_q[$];

    function automatic int model_eval();
        int s;
        s = 0;
        for (int i = 0; i < N; i++)
            s += int'(cx[i]) * int'(dx[i]) + int'(cy[i]) * int'(dy[i]);
        s += int'(off);
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`ifdef NEURON_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = -1;
            m_result = 0;
            exp_q.delete();
        end else if (m_cnt < 0) begin
            if (Start) begin
                m_cnt = 0;
                exp_q.push_back(W'(model_eval()));
            end
        end else begin
            m_cnt++;
            if (m_cnt == N + 2 && exp_q.size() > 0) m_result = int'(exp_q.pop_front());
            if (m_cnt == N + 3) m_cnt = -1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int done_cnt = 0;
    int en_cnt = 0;

    always @(negedge CLK) begin
        if (reset_n) begin
            check("busy", Busy, (m_cnt >= 0) ? 1 : 0);
            check("done", Done, (m_cnt == N + 2) ? 1 : 0);
            check("enable", EnableRegisterIn, (m_cnt == 0) ? 1 : 0);
            check("sel_x", SELCoeffX, (m_cnt >= 1 && m_cnt <= N) ? m_cnt - 1 : 0);
            check("sel_y", SELCoeffY, (m_cnt >= 1 && m_cnt <= N) ? m_cnt - 1 : 0);
            check("result", Result, m_result);
            done_cnt += int'(Done);
            en_cnt   += int'(EnableRegisterIn);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_vec();
        for (int i = 0; i < 16; i++) begin
            cx[i] = '0; cy[i] = '0; dx[i] = '0; dy[i] = '0;
        end
        off = '0;
    endtask

    // Returns 2 time units after the edge that samples Start (edge 0).
    task automatic pulse_start();
        @(posedge CLK); #2 Start = 1'b1;
        @(posedge CLK); #2 Start = 1'b0;
    endtask

    task automatic watch(input int cycles, output int first_done, output int ndone);
        first_done = -1;
        ndone = 0;
        for (int c = 1; c <= cycles; c++) begin
            @(posedge CLK); #1;
            if (Done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
        end
    endtask

    // ---------------- directed tests ----------------
    int first, nd;
    int done_at[$];

    initial begin
        clear_vec();

        // Reset state
        #3;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_en", EnableRegisterIn, 0);
        check("rst_sel", SELCoeffX, 0);
        check("rst_result", Result, 0);
        @(posedge CLK); #2 reset_n = 1'b1;
        repeat (2) @(posedge CLK);

        // Basic MAC: 2*3 - 1 = 5
        clear_vec();
        cx[0] = 4'sd2; dx[0] = 4'sd3; off = -4'sd1;
        en_cnt = 0;
        pulse_start();
        watch(20, first, nd);
        check("basic_latency", first, 12);
        check("basic_ndone", nd, 1);
        check("basic_en_once", en_cnt, 1);
        check("basic_result", Result, 5);

        // Positive saturation: 20 -> 7
        clear_vec();
        for (int i = 0; i < N; i++) begin
            cx[i] = 4'sd1; cy[i] = 4'sd1; dx[i] = 4'sd1; dy[i] = 4'sd1;
        end
        pulse_start();
        watch(16, first, nd);
        check("possat_latency", first, 12);
        check("possat_result", Result, 7);

        // Negative saturation: -568 -> -8 (0 with ReLU)
        clear_vec();
        for (int i = 0; i < N; i++) begin
            cx[i] = -4'sd8; dx[i] = 4'sd7;
        end
        off = -4'sd8;
        pulse_start();
        watch(16, first, nd);
`ifdef NEURON_SEQ_RELU_EN
        check("negsat_result", Result, 0);
`else
        check("negsat_result", Result, -8);
`endif

        // Start ignored while busy: -2*3 + 1*-1 + 2 = -5
        clear_vec();
        cx[3] = -4'sd2; dx[3] = 4'sd3; cy[9] = 4'sd1; dy[9] = -4'sd1; off = 4'sd2;
        done_cnt = 0;
        pulse_start();
        repeat (4) @(posedge CLK);
        #2 Start = 1'b1;
        @(posedge CLK); #2 Start = 1'b0;
        watch(20, first, nd);
        check("ignore_ndone", done_cnt, 1);
        pulse_start();
        watch(16, first, nd);
        check("ignore_second_latency", first, 12);
        check("ignore_result", Result, -5);

        // Reset mid-ACCUM
        clear_vec();
        cx[0] = 4'sd2; dx[0] = 4'sd3; off = -4'sd1;
        pulse_start();
        repeat (6) @(posedge CLK);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_sel", SELCoeffX, 0);
        check("midrst_en", EnableRegisterIn, 0);
        check("midrst_result", Result, 0);
        repeat (2) @(posedge CLK);
        #2 reset_n = 1'b1;
        watch(20, first, nd);
        check("midrst_no_done", nd, 0);
        pulse_start();
        watch(16, first, nd);
        check("midrst_restart_latency", first, 12);
        check("midrst_restart_result", Result, 5);

        // Held Start for 30 cycles
        clear_vec();
        for (int i = 0; i < N; i++) begin
            cx[i] = 4'sd1; cy[i] = 4'sd1; dx[i] = 4'sd1; dy[i] = 4'sd1;
        end
        @(posedge CLK); #2 Start = 1'b1;
        @(posedge CLK);
        done_at.delete();
        for (int c = 1; c <= 30; c++) begin
            @(posedge CLK); #1;
            if (Done) done_at.push_back(c);
            if (c == 29) begin
                #1 Start = 1'b0;
            end
        end
        check("held_ndone", done_at.size(), 2);
        if (done_at.size() == 2) begin
            check("held_done0", done_at[0], 12);
            check("held_done1", done_at[1], 26);
        end
        repeat (20) @(posedge CLK);
        check("held_result", Result, 7);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
